// File: rtl/shift_op_sequencer_if.sv
// shift_op_sequencer_if
// Bundles the request, shifter-drive, result and status signals of the
// shift-operation sequencer into one interface.
//   slave  modport : the sequencer side (accepts requests, drives the shifter,
//                    presents results and status).
//   master modport : the environment side (producer, shifter, consumer).
// Ports carried:
//   in_valid/in_ready/in_data/in_amt      request handshake
//   sh_a/sh_c/sh_o                        to/from the combinational shifter
//   out_valid/out_ready/out_data/out_amt  result handshake
//   count/busy                            occupancy status
interface shift_op_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic [DATA_W-1:0] sh_a;
  logic [AMT_W-1:0]  sh_c;
  logic [DATA_W-1:0] sh_o;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [AMT_W-1:0]  out_amt;
  logic [CNT_W-1:0]  count;
  logic              busy;

  modport slave (
    input  in_valid, in_data, in_amt, sh_o, out_ready,
    output in_ready, sh_a, sh_c, out_valid, out_data, out_amt, count, busy
  );

  modport master (
    output in_valid, in_data, in_amt, sh_o, out_ready,
    input  in_ready, sh_a, sh_c, out_valid, out_data, out_amt, count, busy
  );
endinterface

// File: rtl/shift_op_sequencer.sv
// shift_op_sequencer
// Sequential front/back end for an external combinational barrel shifter.
// Requests {operand, amount} are queued in a DEPTH-entry FIFO; the head entry
// drives the shifter inputs, and the shifter output is captured into a
// registered result stage with a valid/ready handshake.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (flushes queue and pending result)
//   bus  shift_op_sequencer_if.slave (request, shifter, result, status)
module shift_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_op_sequencer_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [AMT_W-1:0]  amt_mem_q  [DEPTH];
  logic [AMT_W-1:0]  amt_mem_d  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [AMT_W-1:0]  out_amt_q, out_amt_d;

  logic              not_empty;
  logic              in_ready;
  logic              push;
  logic              issue;
  logic [DATA_W-1:0] head_a;
  logic [AMT_W-1:0]  head_c;

  // in_ready deliberately ignores a same-cycle pop, so a full FIFO
  // rejects a request even while it is issuing.
  always_comb begin
    not_empty = (count_q != '0);
    in_ready  = (count_q < CNT_W'(DEPTH));
    push      = bus.in_valid & in_ready;
    issue     = not_empty & (~out_valid_q | bus.out_ready);
    head_a    = not_empty ? data_mem_q[rd_ptr_q] : '0;
    head_c    = not_empty ? amt_mem_q[rd_ptr_q]  : '0;
  end

  assign bus.in_ready  = in_ready;
  assign bus.sh_a      = head_a;
  assign bus.sh_c      = head_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_amt   = out_amt_q;
  assign bus.count     = count_q;
  assign bus.busy      = not_empty | out_valid_q;

  always_comb begin
    data_mem_d  = data_mem_q;
    amt_mem_d   = amt_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_amt_d   = out_amt_q;

    if (push) begin
      data_mem_d[wr_ptr_q] = bus.in_data;
      amt_mem_d[wr_ptr_q]  = bus.in_amt;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end

    // The shifter is combinational, so its output for the head entry is
    // already valid in the issue cycle and can be captured directly.
    if (issue) begin
      out_data_d  = bus.sh_o;
      out_amt_d   = head_c;
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end else if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({push, issue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        amt_mem_q[i]  <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_amt_q   <= '0;
    end else begin
      data_mem_q  <= data_mem_d;
      amt_mem_q   <= amt_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_amt_q   <= out_amt_d;
    end
  end
endmodule

// File: tb/tb_shift_op_sequencer.sv
// tb_shift_op_sequencer
// Directed bench for shift_op_sequencer with a queue-based reference model
// and a stub shifter (O = A ^ zero-extended C).
module tb_shift_op_sequencer;
  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_op_sequencer_if #(.DATA_W(DATA_W), .AMT_W(AMT_W), .DEPTH(DEPTH)) bus ();

  assign bus.sh_o = bus.sh_a ^ {{(DATA_W-AMT_W){1'b0}}, bus.sh_c};

  shift_op_sequencer #(.DATA_W(DATA_W), .AMT_W(AMT_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue of pending requests plus one result slot.
  logic [DATA_W-1:0] mq_data [$];
  logic [AMT_W-1:0]  mq_amt  [$];
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [AMT_W-1:0]  m_amt;
  bit                model_live = 1'b0;
  bit                m_push;
  bit                m_issue;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [AMT_W-1:0] a,
                               input logic ordy, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.out_ready = ordy;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  // Advance the model on every edge using the inputs the DUT also sees.
  always @(posedge clk) begin
    if (rst) begin
      mq_data.delete();
      mq_amt.delete();
      m_valid    = 1'b0;
      m_data     = '0;
      m_amt      = '0;
      model_live = 1'b1;
    end else if (model_live) begin
      m_push  = bus.in_valid && (mq_data.size() < DEPTH);
      m_issue = (mq_data.size() != 0) && (!m_valid || bus.out_ready);
      if (m_issue) begin
        m_data  = mq_data[0] ^ DATA_W'(mq_amt[0]);
        m_amt   = mq_amt[0];
        m_valid = 1'b1;
        void'(mq_data.pop_front());
        void'(mq_amt.pop_front());
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (m_push) begin
        mq_data.push_back(bus.in_data);
        mq_amt.push_back(bus.in_amt);
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("out_valid", 32'(bus.out_valid), 32'(m_valid));
      checkOutput("out_data",  32'(bus.out_data),  32'(m_data));
      checkOutput("out_amt",   32'(bus.out_amt),   32'(m_amt));
      checkOutput("count",     32'(bus.count),     32'(mq_data.size()));
      checkOutput("in_ready",  32'(bus.in_ready),  32'(mq_data.size() < DEPTH));
      checkOutput("busy",      32'(bus.busy),      32'((mq_data.size() != 0) || m_valid));
      checkOutput("sh_a", 32'(bus.sh_a), (mq_data.size() != 0) ? 32'(mq_data[0]) : 32'h0);
      checkOutput("sh_c", 32'(bus.sh_c), (mq_amt.size()  != 0) ? 32'(mq_amt[0])  : 32'h0);
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", 32'(bus.count), 32'h0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Single request: result valid after the second edge.
    applyStimulus(1'b1, 16'hAAAA, 4'h1, 1'b1, 1'b0);
    checkOutput("single_pending", 32'(bus.out_valid), 32'h0);
    checkOutput("single_count1", 32'(bus.count), 32'h1);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    checkOutput("single_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("single_data", 32'(bus.out_data), 32'hAAAB);
    checkOutput("single_amt", 32'(bus.out_amt), 32'h1);
    checkOutput("single_count0", 32'(bus.count), 32'h0);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);

    // Back-to-back requests.
    applyStimulus(1'b1, 16'h8001, 4'h4, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0F0F, 4'h0, 1'b1, 1'b0);
    checkOutput("b2b_first", 32'(bus.out_data), 32'h8005);
    checkOutput("b2b_first_amt", 32'(bus.out_amt), 32'h4);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    checkOutput("b2b_second", 32'(bus.out_data), 32'h0F0F);
    checkOutput("b2b_second_valid", 32'(bus.out_valid), 32'h1);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    checkOutput("b2b_busy_low", 32'(bus.busy), 32'h0);

    // Fill under backpressure.
    applyStimulus(1'b1, 16'h0001, 4'h0, 1'b0, 1'b0);
    checkOutput("full_count1", 32'(bus.count), 32'h1);
    for (int k = 2; k <= 5; k++) begin
      applyStimulus(1'b1, DATA_W'(k), 4'h0, 1'b0, 1'b0);
      checkOutput("full_hold_data", 32'(bus.out_data), 32'h0001);
    end
    checkOutput("full_count4", 32'(bus.count), 32'h4);
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'h0);
    // Sixth request is offered but must stall.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 16'h0006, 4'h0, 1'b0, 1'b0);
      checkOutput("stall_count", 32'(bus.count), 32'h4);
      checkOutput("stall_data", 32'(bus.out_data), 32'h0001);
    end

    // Drain with wrap; the sixth request gets in once in_ready returns.
    applyStimulus(1'b1, 16'h0006, 4'h0, 1'b1, 1'b0);
    checkOutput("drain_2", 32'(bus.out_data), 32'h0002);
    checkOutput("drain_count3", 32'(bus.count), 32'h3);
    checkOutput("drain_in_ready", 32'(bus.in_ready), 32'h1);
    applyStimulus(1'b1, 16'h0006, 4'h0, 1'b1, 1'b0);
    checkOutput("drain_3", 32'(bus.out_data), 32'h0003);
    checkOutput("drain_count_push", 32'(bus.count), 32'h3);
    for (int k = 4; k <= 6; k++) begin
      applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
      checkOutput("drain_seq", 32'(bus.out_data), 32'(k));
    end
    checkOutput("drain_count0", 32'(bus.count), 32'h0);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    checkOutput("drain_done", 32'(bus.out_valid), 32'h0);

    // Simultaneous push and issue at count=2.
    applyStimulus(1'b1, 16'h1000, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2000, 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3000, 4'h3, 1'b0, 1'b0);
    checkOutput("sim_count2", 32'(bus.count), 32'h2);
    applyStimulus(1'b1, 16'h4000, 4'h4, 1'b1, 1'b0);
    checkOutput("sim_count_hold", 32'(bus.count), 32'h2);
    checkOutput("sim_out_b", 32'(bus.out_data), 32'h2002);
    applyStimulus(1'b1, 16'h5000, 4'h5, 1'b1, 1'b0);
    checkOutput("sim_count_hold2", 32'(bus.count), 32'h2);
    checkOutput("sim_out_c", 32'(bus.out_data), 32'h3003);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    checkOutput("sim_out_d", 32'(bus.out_data), 32'h4004);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    checkOutput("sim_out_e", 32'(bus.out_data), 32'h5005);
    checkOutput("sim_out_e_amt", 32'(bus.out_amt), 32'h5);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);

    // Reset mid-operation with count=3 and a pending result.
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b1, DATA_W'(16'h00A0 + k), 4'h2, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(bus.count), 32'h3);
    checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
    checkOutput("mid_rst_count", 32'(bus.count), 32'h0);
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("mid_rst_data", 32'(bus.out_data), 32'h0);
    checkOutput("mid_rst_sh_a", 32'(bus.sh_a), 32'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
      checkOutput("no_stale", 32'(bus.out_valid), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shift_op_sequencer.md
Name: shift_op_sequencer

Overview:
- Sequential front/back end for the team's combinational 16-bit barrel shifter.
- Buffers incoming {operand, shift amount} requests in a small FIFO and presents the head entry on the shifter's A/C inputs.
- Captures the shifter's O output into a registered result stage with a valid/ready handshake.
- The shifter is instantiated beside this block, not inside it. This block owns sequencing only, never the shift function.

Parameters:
- DATA_W, 16, operand/result width (matches shifter A/O).
- AMT_W, 4, shift-amount width (matches shifter C).
- DEPTH, 4, request FIFO depth; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  FIFO can accept a request.
- in_data  input  DATA_W  operand.
- in_amt  input  AMT_W  shift amount.
- sh_a  output  DATA_W  to shifter A.
- sh_c  output  AMT_W  to shifter C.
- sh_o  input  DATA_W  from shifter O.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_W  registered shift result.
- out_amt  output  AMT_W  shift amount that produced out_data.
- count  output  clog2(DEPTH)+1  FIFO occupancy.
- busy  output  1  high when count!=0 or out_valid.

Behaviour:
- Reset (synchronous, highest priority):
  - Write pointer, read pointer and count go to 0; out_valid, out_data and out_amt go to 0.
  - Asserting rst mid-operation flushes all queued requests and any pending result on that edge; nothing is emitted afterwards.
- Accept:
  - push = in_valid & in_ready.
  - in_ready = (count < DEPTH). in_ready does not look ahead to a same-cycle pop, so a full FIFO rejects the request even while popping.
  - On push, {in_data, in_amt} is written at the write pointer, and the pointer wraps modulo DEPTH.
- Shifter drive:
  - sh_a/sh_c are driven combinationally from the FIFO head storage when count!=0, and are 0 when empty.
  - The shifter is combinational, so sh_o is valid in the same cycle.
- Issue:
  - issue = (count!=0) & (!out_valid | out_ready).
  - On issue, out_data<=sh_o and out_amt<=sh_c, out_valid<=1, and the read pointer advances with wrap.
- Drain: if out_valid & out_ready & !issue, then out_valid<=0. out_data and out_amt hold their last values.
- Occupancy: count updates +1 on push only, -1 on issue only, and is unchanged on both or neither.
- Latency:
  - A request accepted at edge N is issued at edge N+1 at the earliest, so out_valid is high after edge N+1.
  - There is no empty-FIFO bypass.
- Throughput: one result per cycle when out_ready is held high.
- Backpressure:
  - With out_ready low, the result register holds its value.
  - The FIFO fills to DEPTH, and in_ready then drops.
- Ordering: results emerge strictly in request order. Each out_amt matches the in_amt of its request.
- The block never drops, duplicates or reorders a request, and out_data is stable while out_valid & !out_ready.

Test Plan:
- In the bench, sh_o is driven by a stub: sh_o = sh_a ^ {{(DATA_W-AMT_W){1'b0}}, sh_c}.
- Single request: push in_data=16'hAAAA, in_amt=4'h1 with out_ready=1. Require out_valid high after the 2nd edge, out_data=16'hAAAB, out_amt=1, and count back to 0.
- Back-to-back: push 16'h8001/4 then 16'h0F0F/0 on consecutive cycles with out_ready=1. Require outputs 16'h8005 then 16'h0F0F in consecutive cycles, in that order, and busy then falls.
- Full FIFO with backpressure:
  - Hold out_ready=0 and push 5 requests (16'h0001..16'h0005, amt 0).
  - Require 1 issued to the result register, then 4 more accepted and count=4.
  - Require in_ready=0 while count=4, and out_data=16'h0001 held stable.
  - The 6th push stalls until in_ready returns.
- Drain with wrap: after the full-FIFO scenario, raise out_ready. Require results 1..5 in order on consecutive cycles with the read pointer wrapping past DEPTH-1, and a final count=0.
- Simultaneous push/issue at count=2: require count stays 2 and data order is preserved.
- Reset mid-operation:
  - Assert rst for one cycle while count=3 and out_valid=1.
  - Require count=0, out_valid=0, out_data=0 and sh_a=0 on the next cycle.
  - Require that no stale results appear afterwards.
